// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with valid/ready handshakes.
//
// Decodes the main-control ALU op class and the R-type funct field into a
// 4-bit ALU control word. Multiply/divide ops are sequenced through an
// external iterative unit: a one-cycle md_start pulse, then the block holds
// off new issues for MD_LAT cycles before presenting the result.
//
// Build option: define ALU_CTRL_MULDIV_EN to decode mult/multu/div/divu and
// build the MD_RUN state and latency counter. When it is undefined those
// functs decode as illegal single-cycle ops and md_start/md_op/busy are 0.
//
// Handshake rules (both ports):
//   A transfer happens at a rising clk edge where valid && ready are high.
//   Upstream: in_ready = (state == IDLE) && (!out_valid || out_ready).
//   Downstream: while out_valid && !out_ready, alu_ctrl, illegal and md_op
//   hold stable. A consume and a new accept may share the same edge.
module alu_ctrl_seq #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_ctrl,
    output logic       illegal,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       busy,
    output logic       o_dbg_state
);

    logic [3:0] w_dec_ctrl;
    logic       w_dec_illegal;
    logic       w_dec_md;
    logic       w_accept;
    logic       w_consume;

    logic [3:0] r_alu_ctrl;
    logic       r_illegal;
    logic       r_out_valid;

    // Combinational decode of the incoming op.
    always_comb begin
        w_dec_ctrl    = 4'b0000;
        w_dec_illegal = 1'b0;
        w_dec_md      = 1'b0;
        case (alu_op)
            2'b00: w_dec_ctrl = 4'b0010;
            2'b01: w_dec_ctrl = 4'b0110;
            2'b11: w_dec_ctrl = 4'b0111;
            default: begin
                case (funct)
                    6'b100000: w_dec_ctrl = 4'b0010;
                    6'b100010: w_dec_ctrl = 4'b0110;
                    6'b100100: w_dec_ctrl = 4'b0000;
                    6'b100101: w_dec_ctrl = 4'b0001;
                    6'b100111: w_dec_ctrl = 4'b1100;
                    6'b101010: w_dec_ctrl = 4'b0111;
`ifdef ALU_CTRL_MULDIV_EN
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        w_dec_ctrl = {2'b10, funct[1:0]};
                        w_dec_md   = 1'b1;
                    end
`endif
                    default: begin
                        w_dec_ctrl    = 4'b0000;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign illegal   = r_illegal;

`ifdef ALU_CTRL_MULDIV_EN

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_MD_RUN = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_md_start;
    logic [1:0]       r_md_op;
    logic             r_busy;

    assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign md_start    = r_md_start;
    assign md_op       = r_md_op;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

    // Control FSM: accepts ops in IDLE, counts mul/div latency in MD_RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_md_start  <= 1'b0;
            r_md_op     <= 2'b00;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= 4'b0000;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_md_start <= 1'b0;
                    if (w_consume) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_alu_ctrl <= w_dec_ctrl;
                        r_illegal  <= w_dec_illegal;
                        if (w_dec_md) begin
                            // Result is withheld until the external unit finishes.
                            r_state     <= S_MD_RUN;
                            r_cnt       <= CNT_W'(MD_LAT - 1);
                            r_md_start  <= 1'b1;
                            r_md_op     <= funct[1:0];
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MD_RUN: begin
                    r_md_start <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`else

    // Latency parameters only matter when the mul/div path is built.
    logic [CNT_W-1:0] w_unused_cfg;
    assign w_unused_cfg = CNT_W'(MD_LAT);

    assign in_ready    = !r_out_valid || out_ready;
    assign md_start    = 1'b0;
    assign md_op       = 2'b00;
    assign busy        = 1'b0;
    assign o_dbg_state = 1'b0;

    // Output register: loads on accept, clears when consumed with no new op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= 4'b0000;
            r_illegal   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_ctrl  <= w_dec_ctrl;
                r_illegal   <= w_dec_illegal;
                r_out_valid <= 1'b1;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed testbench for alu_ctrl_seq (MD_LAT=4). Expectations adapt to
// whether ALU_CTRL_MULDIV_EN is defined for the build.
module tb_alu_ctrl_seq;

  localparam int MD_LAT = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic       md_start;
  logic [1:0] md_op;
  logic       busy;
  logic       dbg_state;

  int n_vec;
  int n_err;
  int n_md_start;

  alu_ctrl_seq #(.MD_LAT(MD_LAT), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_ctrl    (alu_ctrl),
    .illegal     (illegal),
    .md_start    (md_start),
    .md_op       (md_op),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count md_start pulses seen at clock edges
  always @(posedge clk) begin
    if (md_start === 1'b1) n_md_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
    in_valid = v;
    alu_op   = op;
    funct    = f;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  8'(in_ready),  8'h1);
    check({tag, "_out_valid"}, 8'(out_valid), 8'h0);
    check({tag, "_alu_ctrl"},  8'(alu_ctrl),  8'h0);
    check({tag, "_illegal"},   8'(illegal),   8'h0);
    check({tag, "_md_start"},  8'(md_start),  8'h0);
    check({tag, "_md_op"},     8'(md_op),     8'h0);
    check({tag, "_busy"},      8'(busy),      8'h0);
    check({tag, "_state"},     8'(dbg_state), 8'h0);
  endtask

  logic [5:0] f_tab [6];
  logic [3:0] c_tab [6];
  int exp_md_pulses;

  initial begin
    n_vec = 0;
    n_err = 0;
    n_md_start = 0;
    exp_md_pulses = 0;
    f_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    c_tab = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b1100,   4'b0111};

    // reset
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 6'b000000);
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", 8'(out_valid), 8'h0);

    // back-to-back non-R ops
    drive(1'b1, 2'b00, 6'b000000);
    tick();
    check("op00_valid", 8'(out_valid), 8'h1);
    check("op00_ctrl",  8'(alu_ctrl),  8'h2);
    check("op00_ready", 8'(in_ready),  8'h1);
    drive(1'b1, 2'b01, 6'b000000);
    tick();
    check("op01_ctrl",  8'(alu_ctrl),  8'h6);
    check("op01_ready", 8'(in_ready),  8'h1);
    drive(1'b1, 2'b11, 6'b000000);
    tick();
    check("op11_ctrl",  8'(alu_ctrl),  8'h7);
    check("op11_valid", 8'(out_valid), 8'h1);

    // R-type single-cycle functs, one per cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b10, f_tab[i]);
      tick();
      check($sformatf("rtype%0d_ctrl", i), 8'(alu_ctrl),  8'(c_tab[i]));
      check($sformatf("rtype%0d_ill", i),  8'(illegal),   8'h0);
      check($sformatf("rtype%0d_vld", i),  8'(out_valid), 8'h1);
    end

    // unsupported funct
    drive(1'b1, 2'b10, 6'b000111);
    tick();
    check("ill_ctrl",  8'(alu_ctrl),  8'h0);
    check("ill_flag",  8'(illegal),   8'h1);
    check("ill_start", 8'(md_start),  8'h0);
    drive(1'b0, 2'b00, 6'b000000);
    tick();
    check("drain_valid", 8'(out_valid), 8'h0);

    // backpressure after an or-op
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 6'b100101);
    tick();
    check("bp_first_ctrl", 8'(alu_ctrl), 8'h1);
    drive(1'b1, 2'b01, 6'b000000);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_ctrl", i),  8'(alu_ctrl),  8'h1);
      check($sformatf("bp%0d_valid", i), 8'(out_valid), 8'h1);
      check($sformatf("bp%0d_ready", i), 8'(in_ready),  8'h0);
      check($sformatf("bp%0d_ill", i),   8'(illegal),   8'h0);
      tick();
    end
    check("bp_end_ctrl", 8'(alu_ctrl), 8'h1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 8'(in_ready), 8'h1);
    tick();
    check("bp_same_edge_valid", 8'(out_valid), 8'h1);
    check("bp_same_edge_ctrl",  8'(alu_ctrl),  8'h6);
    drive(1'b0, 2'b00, 6'b000000);
    tick();
    check("bp_drain_valid", 8'(out_valid), 8'h0);

`ifdef ALU_CTRL_MULDIV_EN
    // divu through the external unit; a competing op waits in in_valid
    drive(1'b1, 2'b10, 6'b011011);
    tick();
    exp_md_pulses++;
    drive(1'b1, 2'b00, 6'b000000);
    check("md_start_c0", 8'(md_start),  8'h1);
    check("md_op_c0",    8'(md_op),     8'h3);
    check("md_busy_c0",  8'(busy),      8'h1);
    check("md_ready_c0", 8'(in_ready),  8'h0);
    check("md_valid_c0", 8'(out_valid), 8'h0);
    check("md_state_c0", 8'(dbg_state), 8'h1);
    for (int i = 1; i < MD_LAT; i++) begin
      tick();
      check($sformatf("md_start_c%0d", i), 8'(md_start),  8'h0);
      check($sformatf("md_busy_c%0d", i),  8'(busy),      8'h1);
      check($sformatf("md_valid_c%0d", i), 8'(out_valid), 8'h0);
      check($sformatf("md_ready_c%0d", i), 8'(in_ready),  8'h0);
    end
    tick();
    check("md_done_busy",  8'(busy),      8'h0);
    check("md_done_valid", 8'(out_valid), 8'h1);
    check("md_done_ctrl",  8'(alu_ctrl),  8'hb);
    check("md_done_ill",   8'(illegal),   8'h0);
    check("md_done_op",    8'(md_op),     8'h3);
    check("md_done_ready", 8'(in_ready),  8'h1);
    tick();
    check("md_next_ctrl",  8'(alu_ctrl),  8'h2);
    check("md_next_valid", 8'(out_valid), 8'h1);
    drive(1'b0, 2'b00, 6'b000000);
    tick();
    check("md_drain_valid", 8'(out_valid), 8'h0);

    // reset two cycles into a mult
    drive(1'b1, 2'b10, 6'b011000);
    tick();
    exp_md_pulses++;
    drive(1'b0, 2'b00, 6'b000000);
    check("mrst_busy_pre", 8'(busy), 8'h1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mrst");
`else
    // mult without the mul/div build: illegal single-cycle op
    drive(1'b1, 2'b10, 6'b011000);
    tick();
    drive(1'b0, 2'b00, 6'b000000);
    check("nomd_valid", 8'(out_valid), 8'h1);
    check("nomd_ctrl",  8'(alu_ctrl),  8'h0);
    check("nomd_ill",   8'(illegal),   8'h1);
    check("nomd_start", 8'(md_start),  8'h0);
    check("nomd_busy",  8'(busy),      8'h0);
    check("nomd_op",    8'(md_op),     8'h0);
    out_ready = 1'b0;
    tick();
    check("nomd_hold_ill", 8'(illegal), 8'h1);
    rst_n = 1'b0;
    #1;
    out_ready = 1'b1;
    #1;
    check_reset_outputs("nrst");
`endif

    tick();
    rst_n = 1'b1;
    for (int i = 0; i < MD_LAT + 3; i++) begin
      tick();
      check($sformatf("rel%0d_valid", i), 8'(out_valid), 8'h0);
      check($sformatf("rel%0d_start", i), 8'(md_start),  8'h0);
      check($sformatf("rel%0d_ready", i), 8'(in_ready),  8'h1);
    end
    check("md_start_pulses", 8'(n_md_start), 8'(exp_md_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
